// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//   Moore control sequencer for an 8-register, single-bus datapath. It accepts
//   one instruction over a valid/ready handshake. It then steps the datapath
//   through IDLE -> T1 [-> T2 -> T3] -> IDLE, driving bus buffers, register
//   loads, A/G loads, the G output and a one-hot ALU op.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   instr_valid  instruction word present on instr
//   instr_ready  accept possible (IDLE, out of reset)
//   instr        [9:6] opcode, [5:3] rx, [2:0] ry
//   data_in      LOAD immediate, sampled on accept
//   d            latched immediate for the data tri-state buffer
//   data_out     data buffer onto bus
//   bus_buf_en   register->bus enables, bit7=R0 .. bit0=R7
//   reg_en       register load enables, bit7=R0 .. bit0=R7
//   a_in/g_in    load A from bus / load G from ALU
//   g_out        G onto bus
//   math_en      one-hot ALU op: b0 ADD, b1 SUB, b2 XOR, b3 AND, b4 OR
//   busy         not IDLE
//   done         one-cycle pulse in the last step of each instruction
//   illegal      sticky, an opcode 8..15 was accepted
//   instr_count  completed instructions, wraps
// -----------------------------------------------------------------------------
module bus_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [9:0]       instr,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] d,
   output logic             data_out,
   output logic [7:0]       bus_buf_en,
   output logic [7:0]       reg_en,
   output logic             a_in,
   output logic             g_in,
   output logic             g_out,
   output logic [6:0]       math_en,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q;
   logic [2:0]       rx_q, ry_q;
   logic [WIDTH-1:0] d_q;
   logic             accept;

   // Register index to enable bit; R0 sits in the MSB.
   function automatic logic [7:0] reg_sel(input logic [2:0] r);
      return 8'h80 >> r;
   endfunction

   assign accept      = (state_q == IDLE) && instr_valid;
   // Held low while rst is asserted so nothing looks acceptable in reset.
   assign instr_ready = (state_q == IDLE) && rst;
   assign busy        = (state_q != IDLE);
   assign d           = d_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         rx_q        <= '0;
         ry_q        <= '0;
         d_q         <= '0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= instr[9:6];
            rx_q <= instr[5:3];
            ry_q <= instr[2:0];
            d_q  <= data_in;
            if (instr[9]) illegal <= 1'b1;
         end
         if (done) instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Outputs depend only on state and latched fields (Moore).
   always_comb begin
      state_d    = state_q;
      data_out   = 1'b0;
      bus_buf_en = '0;
      reg_en     = '0;
      a_in       = 1'b0;
      g_in       = 1'b0;
      g_out      = 1'b0;
      math_en    = '0;
      done       = 1'b0;
      case (state_q)
         IDLE: if (instr_valid) state_d = T1;
         T1: begin
            case (op_q)
               4'd0: begin                          // LOAD
                  data_out = 1'b1;
                  reg_en   = reg_sel(rx_q);
                  done     = 1'b1;
                  state_d  = IDLE;
               end
               4'd1: begin                          // MOV
                  bus_buf_en = reg_sel(ry_q);
                  reg_en     = reg_sel(rx_q);
                  done       = 1'b1;
                  state_d    = IDLE;
               end
               4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin  // ALU: rx -> A
                  bus_buf_en = reg_sel(rx_q);
                  a_in       = 1'b1;
                  state_d    = T2;
               end
               default: begin                       // NOP and illegal opcodes
                  done    = 1'b1;
                  state_d = IDLE;
               end
            endcase
         end
         T2: begin                                  // ry on bus, ALU -> G
            bus_buf_en = reg_sel(ry_q);
            math_en    = 7'b1 << (op_q - 4'd2);
            g_in       = 1'b1;
            state_d    = T3;
         end
         T3: begin                                  // G -> rx
            g_out   = 1'b1;
            reg_en  = reg_sel(rx_q);
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_sequencer.sv
module tb_bus_sequencer;
   // An 8-bit counter keeps the wrap check within a short run.
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [9:0]    instr = '0;
   logic [15:0]   data_in = '0;
   logic [15:0]   d;
   logic          data_out, a_in, g_in, g_out, busy, done, illegal;
   logic [7:0]    bus_buf_en, reg_en;
   logic [6:0]    math_en;
   logic [CW-1:0] instr_count;

   bus_sequencer #(.WIDTH(16), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .data_in(data_in), .d(d), .data_out(data_out),
      .bus_buf_en(bus_buf_en), .reg_en(reg_en), .a_in(a_in), .g_in(g_in),
      .g_out(g_out), .math_en(math_en), .busy(busy), .done(done),
      .illegal(illegal), .instr_count(instr_count));

   always #5 clk = ~clk;

   typedef struct packed {
      logic rdy; logic busy; logic done; logic dout; logic ain; logic gin; logic gout;
      logic [7:0] bb; logic [7:0] re; logic [6:0] me;
   } outs_t;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: queue of per-cycle output records for the instruction in flight
   outs_t         sched[$];
   outs_t         cur;
   logic [CW-1:0] m_cnt;
   logic          m_ill;
   logic [15:0]   m_d;

   function automatic outs_t mk(input logic rdy, bsy, dn, dout, ain, gin, gout,
                                input logic [7:0] bb, re, input logic [6:0] me);
      outs_t o;
      o = {rdy, bsy, dn, dout, ain, gin, gout, bb, re, me};
      return o;
   endfunction

   function automatic outs_t idle_rec();
      return mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 7'h00);
   endfunction

   function automatic logic [7:0] oh(input logic [2:0] r);
      logic [7:0] v;
      v = '0;
      v[7 - int'(r)] = 1'b1;
      return v;
   endfunction

   function automatic outs_t act();
      return {instr_ready, busy, done, data_out, a_in, g_in, g_out, bus_buf_en, reg_en, math_en};
   endfunction

   task automatic plan(input logic [3:0] op, input logic [2:0] rx, ry);
      logic [6:0] me;
      me = '0;
      case (op)
         4'd0: sched.push_back(mk(0, 1, 1, 1, 0, 0, 0, 8'h00, oh(rx), 7'h00));
         4'd1: sched.push_back(mk(0, 1, 1, 0, 0, 0, 0, oh(ry), oh(rx), 7'h00));
         4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            me[int'(op) - 2] = 1'b1;
            sched.push_back(mk(0, 1, 0, 0, 1, 0, 0, oh(rx), 8'h00, 7'h00));
            sched.push_back(mk(0, 1, 0, 0, 0, 1, 0, oh(ry), 8'h00, me));
            sched.push_back(mk(0, 1, 1, 0, 0, 0, 1, 8'h00, oh(rx), 7'h00));
         end
         default: sched.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 7'h00));
      endcase
   endtask

   task automatic chk_outs(input string nm, input outs_t exp);
      outs_t a;
      a = act();
      n_cmp++;
      if (a !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, exp);
      end
   endtask

   task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      sched.delete();
      cur   = idle_rec();
      m_cnt = '0;
      m_ill = 1'b0;
      m_d   = '0;
   endtask

   // One clock: drive inputs, advance the model at the edge, sample 1 ns later.
   task automatic tick(input logic v, input logic [3:0] op, input logic [2:0] rx, ry,
                       input logic [15:0] dat, input bit chk);
      instr_valid = v;
      instr       = {op, rx, ry};
      data_in     = dat;
      @(posedge clk);
      if (cur.done) m_cnt = m_cnt + 1'b1;
      if (cur.rdy && v) begin
         plan(op, rx, ry);
         m_d = dat;
         if (op >= 4'd8) m_ill = 1'b1;
      end
      #1;
      cur = (sched.size() != 0) ? sched.pop_front() : idle_rec();
      if (chk) begin
         chk_outs("model_outs", cur);
         chk_val("model_d", 32'(d), 32'(m_d));
         chk_val("model_count", 32'(instr_count), 32'(m_cnt));
         chk_val("model_illegal", 32'(illegal), 32'(m_ill));
      end
   endtask

   task automatic idle_tick();
      tick(0, 4'd7, 3'd0, 3'd0, 16'h0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      instr_valid = 1'b0;
      #1;
      chk_outs("reset_outs", mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 7'h00));
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_val("reset_count", 32'(instr_count), 32'd0);
      chk_val("reset_illegal", 32'(illegal), 32'd0);
      chk_val("reset_d", 32'(d), 32'd0);
      rst = 1'b1;
      model_reset();
      #1;
      chk_outs("reset_release", idle_rec());
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  rx, ry;
      logic [15:0] dat;
      int          lat;
      logic [7:0]  bb1, re1;
      logic        dout1, ain1;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      int c;
      logic [CW-1:0] cnt0;
      vecs[0] = '{4'd0, 3'd3, 3'd0, 16'h1234, 1, 8'h00, 8'h10, 1'b1, 1'b0}; // LOAD R3
      vecs[1] = '{4'd1, 3'd6, 3'd2, 16'h0000, 1, 8'h20, 8'h02, 1'b0, 1'b0}; // MOV R6<-R2
      vecs[2] = '{4'd1, 3'd4, 3'd4, 16'h0000, 1, 8'h08, 8'h08, 1'b0, 1'b0}; // MOV self
      vecs[3] = '{4'd2, 3'd0, 3'd7, 16'h0000, 3, 8'h80, 8'h00, 1'b0, 1'b1}; // ADD R0,R7
      vecs[4] = '{4'd6, 3'd7, 3'd0, 16'h0000, 3, 8'h01, 8'h00, 1'b0, 1'b1}; // OR R7,R0
      vecs[5] = '{4'd7, 3'd0, 3'd0, 16'h0000, 1, 8'h00, 8'h00, 1'b0, 1'b0}; // NOP
      vecs[6] = '{4'd5, 3'd2, 3'd5, 16'h0000, 3, 8'h20, 8'h00, 1'b0, 1'b1}; // AND R2,R5

      model_reset();
      do_reset();

      // LOAD rx=3, data 0x1234
      tick(1, 4'd0, 3'd3, 3'd0, 16'h1234, 1);
      chk_outs("load_t1", mk(0, 1, 1, 1, 0, 0, 0, 8'h00, 8'h10, 7'h00));
      chk_val("load_d", 32'(d), 32'h1234);
      idle_tick();
      chk_val("load_count", 32'(instr_count), 32'd1);

      // ADD rx=1 ry=2, per-step enables
      tick(1, 4'd2, 3'd1, 3'd2, 16'h0, 1);
      chk_outs("add_t1", mk(0, 1, 0, 0, 1, 0, 0, 8'h40, 8'h00, 7'h00));
      idle_tick();
      chk_outs("add_t2", mk(0, 1, 0, 0, 0, 1, 0, 8'h20, 8'h00, 7'h01));
      idle_tick();
      chk_outs("add_t3", mk(0, 1, 1, 0, 0, 0, 1, 8'h00, 8'h40, 7'h00));
      idle_tick();
      chk_outs("add_idle", idle_rec());

      // SUB rx=ry=5 with instr_valid held high
      tick(1, 4'd3, 3'd5, 3'd5, 16'h0, 1);
      chk_outs("sub_t1", mk(0, 1, 0, 0, 1, 0, 0, 8'h04, 8'h00, 7'h00));
      tick(1, 4'd3, 3'd5, 3'd5, 16'h0, 1);
      chk_outs("sub_t2", mk(0, 1, 0, 0, 0, 1, 0, 8'h04, 8'h00, 7'h02));
      tick(1, 4'd3, 3'd5, 3'd5, 16'h0, 1);
      chk_outs("sub_t3", mk(0, 1, 1, 0, 0, 0, 1, 8'h00, 8'h04, 7'h00));
      tick(1, 4'd3, 3'd5, 3'd5, 16'h0, 1);
      chk_outs("sub_gap_idle", idle_rec());
      tick(1, 4'd3, 3'd5, 3'd5, 16'h0, 1);
      chk_outs("sub_reaccept", mk(0, 1, 0, 0, 1, 0, 0, 8'h04, 8'h00, 7'h00));
      idle_tick();
      idle_tick();
      idle_tick();

      // table-driven single instructions
      for (int i = 0; i < 7; i++) begin
         cnt0 = instr_count;
         tick(1, vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].dat, 1);
         chk_val($sformatf("vec%0d_bb", i), 32'(bus_buf_en), 32'(vecs[i].bb1));
         chk_val($sformatf("vec%0d_re", i), 32'(reg_en), 32'(vecs[i].re1));
         chk_val($sformatf("vec%0d_ctl", i), {30'd0, data_out, a_in}, {30'd0, vecs[i].dout1, vecs[i].ain1});
         c = 1;
         while (!done && c < 10) begin
            idle_tick();
            c++;
         end
         chk_val($sformatf("vec%0d_latency", i), 32'(c), 32'(vecs[i].lat));
         idle_tick();
         chk_val($sformatf("vec%0d_count", i), 32'(instr_count), 32'(cnt0 + 1'b1));
      end

      // illegal opcode, sticky across a NOP, cleared by reset
      tick(1, 4'hB, 3'd2, 3'd6, 16'h0, 1);
      chk_outs("ill_t1", mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 7'h00));
      chk_val("ill_flag", 32'(illegal), 32'd1);
      idle_tick();
      tick(1, 4'd7, 3'd0, 3'd0, 16'h0, 1);
      idle_tick();
      chk_val("ill_sticky", 32'(illegal), 32'd1);
      do_reset();

      // reset in T2 of XOR
      tick(1, 4'd4, 3'd1, 3'd3, 16'hBEEF, 1);
      idle_tick();
      chk_outs("xor_t2", mk(0, 1, 0, 0, 0, 1, 0, 8'h10, 8'h00, 7'h04));
      rst = 1'b0;
      #1;
      chk_outs("xor_rst_outs", mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 7'h00));
      chk_val("xor_rst_d", 32'(d), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      chk_outs("xor_rst_release", idle_rec());

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         tick($urandom_range(0, 9) < 7, op, 3'($urandom), 3'($urandom), 16'($urandom), 1);
      end

      // counter wrap: all-ones then one more NOP
      do_reset();
      for (int i = 0; i < (1 << CW) - 1; i++) begin
         tick(1, 4'd7, 3'd0, 3'd0, 16'h0, 0);
         tick(0, 4'd7, 3'd0, 3'd0, 16'h0, 0);
      end
      chk_val("count_all_ones", 32'(instr_count), 32'((1 << CW) - 1));
      tick(1, 4'd7, 3'd0, 3'd0, 16'h0, 1);
      idle_tick();
      chk_val("count_wrap", 32'(instr_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
